xbee_tx_scheduler: RTL and testbench

//  Shares the XBee transmit frame controller between NREQ requesters (sensor/plot channels).

---
 rtl/xbee_tx_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/xbee_tx_scheduler.sv | 156 +++++++++++++++
 tb/tb_xbee_tx_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/xbee_tx_pkg.sv
// Shared definitions for the XBee transmit scheduler: FSM encodings and default timing constants.
package xbee_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARB      = 3'd1,
    ST_LAUNCH   = 3'd2,
    ST_EVLAUNCH = 3'd3,
    ST_WAIT     = 3'd4,
    ST_RELEASE  = 3'd5
  } state_t;

  localparam int DEF_TIMEOUT   = 1023;
  localparam int DEF_RX_PERIOD = 14;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after the pointer, wrapping around.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IDW-1:0]  id,
  output logic            any
);

  always_comb begin
    int j;
    logic [IDW-1:0] jj;
    j      = 0;
    jj     = '0;
    onehot = '0;
    id     = ptr;
    any    = 1'b0;
    // the pointer itself is visited last, so the previous owner has lowest priority
    for (int i = 1; i <= NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      jj = IDW'(j);
      if (!any && req[jj]) begin
        any        = 1'b1;
        onehot[jj] = 1'b1;
        id         = jj;
      end
    end
  end

endmodule

// File: rtl/xbee_tx_scheduler.sv
// Shares the XBee Tx frame controller between NREQ requesters; one ND or Eviction launch per frame,
// grant held until Done or watchdog abort, Rx_Window pulse every RX_PERIOD completed frames.
//
//   state    | meaning
//   IDLE     | no frame; waiting for evict or request
//   ARB      | round-robin pick among Req
//   LAUNCH   | grant registered, ND follows next cycle
//   EVLAUNCH | eviction frame, Eviction follows next cycle
//   WAIT     | frame in flight, watchdog running
//   RELEASE  | frame closed, pointer advanced
module xbee_tx_scheduler
  import xbee_tx_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int IDW       = $clog2(NREQ),
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int RX_PERIOD = DEF_RX_PERIOD
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [NREQ-1:0] Req,
  input  logic            Evict_Req,
  input  logic            Done,
  output logic [NREQ-1:0] Grant,
  output logic [IDW-1:0]  Grant_Id,
  output logic            ND,
  output logic            Eviction,
  output logic            Busy,
  output logic            Timeout_Err,
  output logic            Rx_Window,
  output logic [7:0]      Frame_Cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT);
  localparam logic [3:0]    RX_LAST    = 4'(RX_PERIOD - 1);
  localparam logic [IDW-1:0] PTR_INIT  = IDW'(NREQ - 1);

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [TW-1:0]   timer;
  logic            evict_pend;
  logic            evict_frame;
  logic [3:0]      rx_cnt;

  logic [NREQ-1:0] arb_onehot;
  logic [IDW-1:0]  arb_id;
  logic            arb_any;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (Req),
    .ptr    (ptr),
    .onehot (arb_onehot),
    .id     (arb_id),
    .any    (arb_any)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      ptr         <= PTR_INIT;
      timer       <= '0;
      evict_pend  <= 1'b0;
      evict_frame <= 1'b0;
      rx_cnt      <= '0;
      Grant       <= '0;
      Grant_Id    <= '0;
      ND          <= 1'b0;
      Eviction    <= 1'b0;
      Busy        <= 1'b0;
      Timeout_Err <= 1'b0;
      Rx_Window   <= 1'b0;
      Frame_Cnt   <= '0;
    end else begin
      ND          <= 1'b0;
      Eviction    <= 1'b0;
      Timeout_Err <= 1'b0;
      Rx_Window   <= 1'b0;

      // an eviction arriving mid-frame is parked until the next IDLE
      if (Evict_Req && state != ST_IDLE && state != ST_EVLAUNCH)
        evict_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (evict_pend || Evict_Req) begin
            state <= ST_EVLAUNCH;
            Busy  <= 1'b1;
          end else if (|Req) begin
            state <= ST_ARB;
            Busy  <= 1'b1;
          end
        end
        ST_ARB: begin
          if (arb_any) begin
            Grant       <= arb_onehot;
            Grant_Id    <= arb_id;
            evict_frame <= 1'b0;
            state       <= ST_LAUNCH;
          end else begin
            Busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
          ND    <= 1'b1;
          timer <= TIMER_LOAD;
          state <= ST_WAIT;
        end
        ST_EVLAUNCH: begin
          Eviction    <= 1'b1;
          Grant       <= '0;
          evict_pend  <= 1'b0;
          evict_frame <= 1'b1;
          timer       <= TIMER_LOAD;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          // Done takes precedence over a coincident watchdog expiry
          if (Done) begin
            Grant     <= '0;
            Frame_Cnt <= Frame_Cnt + 8'd1;
            if (rx_cnt == RX_LAST) begin
              rx_cnt    <= '0;
              Rx_Window <= 1'b1;
            end else begin
              rx_cnt <= rx_cnt + 4'd1;
            end
            state <= ST_RELEASE;
          end else if (timer == '0) begin
            Grant       <= '0;
            Timeout_Err <= 1'b1;
            state       <= ST_RELEASE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!evict_frame)
            ptr <= Grant_Id;
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          Grant <= '0;
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xbee_tx_scheduler.sv
// Directed bench for xbee_tx_scheduler: latency, round-robin order, eviction, watchdog, Rx_Window, reset.
module tb_xbee_tx_scheduler;

  logic       Clk;
  logic       Reset;
  logic [3:0] Req;
  logic       Evict_Req;
  logic       Done;
  logic [3:0] Grant;
  logic [1:0] Grant_Id;
  logic       ND;
  logic       Eviction;
  logic       Busy;
  logic       Timeout_Err;
  logic       Rx_Window;
  logic [7:0] Frame_Cnt;

  int tests;
  int fails;
  int nd_seen;
  int rx_seen;
  int exp_fc;
  int exp_rx;

  xbee_tx_scheduler #(
    .NREQ      (4),
    .IDW       (2),
    .TIMEOUT   (1023),
    .RX_PERIOD (14)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Req         (Req),
    .Evict_Req   (Evict_Req),
    .Done        (Done),
    .Grant       (Grant),
    .Grant_Id    (Grant_Id),
    .ND          (ND),
    .Eviction    (Eviction),
    .Busy        (Busy),
    .Timeout_Err (Timeout_Err),
    .Rx_Window   (Rx_Window),
    .Frame_Cnt   (Frame_Cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    if (ND) nd_seen++;
    if (Rx_Window) rx_seen++;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Req = '0; Evict_Req = 1'b0; Done = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    nd_seen = 0; rx_seen = 0; exp_fc = 0; exp_rx = 0;
  endtask

  task automatic expect_launch(input int id, input bit ev);
    int n;
    n = 0;
    while (!(ND || Eviction) && n < 40) begin
      step();
      n++;
    end
    chk("launch_seen", 32'(ND || Eviction), 1);
    if (ev) begin
      chk("evict_pulse", 32'(Eviction), 1);
      chk("evict_grant", 32'(Grant), 0);
    end else begin
      chk("nd_pulse", 32'(ND), 1);
      chk("grant_onehot", 32'(Grant), 32'(1 << id));
      chk("grant_id", 32'(Grant_Id), 32'(id));
    end
    step();
    chk("launch_single", 32'(ND || Eviction), 0);
  endtask

  task automatic finish_frame(input int gap);
    bit pulse;
    repeat (gap) step();
    Done = 1'b1;
    step();
    Done = 1'b0;
    exp_fc = (exp_fc + 1) % 256;
    exp_rx = exp_rx + 1;
    pulse  = (exp_rx == 14);
    if (pulse) exp_rx = 0;
    chk("release_grant", 32'(Grant), 0);
    chk("release_busy", 32'(Busy), 1);
    chk("frame_cnt", 32'(Frame_Cnt), 32'(exp_fc));
    chk("rx_window", 32'(Rx_Window), 32'(pulse));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    tests = 0; fails = 0;
    nd_seen = 0; rx_seen = 0; exp_fc = 0; exp_rx = 0;
    Reset = 1'b1; Req = '0; Evict_Req = 1'b0; Done = 1'b0;
    #1;
    chk("rst_grant", 32'(Grant), 0);
    chk("rst_grant_id", 32'(Grant_Id), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_nd", 32'(ND), 0);
    chk("rst_frame_cnt", 32'(Frame_Cnt), 0);
    @(posedge Clk); #1;
    Reset = 1'b0;

    // 1: single request latency and first frame
    Req = 4'b0001;
    step();
    chk("t1_arb_busy", 32'(Busy), 1);
    chk("t1_arb_grant", 32'(Grant), 0);
    step();
    chk("t1_grant", 32'(Grant), 4'b0001);
    chk("t1_nd_early", 32'(ND), 0);
    step();
    chk("t1_nd", 32'(ND), 1);
    Req = 4'b0000;
    step();
    chk("t1_nd_drop", 32'(ND), 0);
    step();
    Done = 1'b1;
    step();
    Done = 1'b0;
    chk("t1_release_grant", 32'(Grant), 0);
    chk("t1_frame_cnt", 32'(Frame_Cnt), 1);
    step();
    chk("t1_idle_busy", 32'(Busy), 0);
    chk("t1_id_hold", 32'(Grant_Id), 0);
    Done = 1'b1;
    step();
    Done = 1'b0;
    step();
    chk("t1_done_idle_ignored", 32'(Frame_Cnt), 1);

    // 2: round-robin over all four channels
    do_reset();
    Req = 4'b1111;
    expect_launch(0, 1'b0); finish_frame(3);
    expect_launch(1, 1'b0); finish_frame(3);
    expect_launch(2, 1'b0); finish_frame(3);
    expect_launch(3, 1'b0); finish_frame(3);
    expect_launch(0, 1'b0);
    Req = 4'b0000;
    finish_frame(3);
    chk("t2_nd_count", 32'(nd_seen), 5);

    // 3: eviction raised mid-frame is served before the next requester
    do_reset();
    Req = 4'b0110;
    expect_launch(1, 1'b0);
    Evict_Req = 1'b1;
    step();
    Evict_Req = 1'b0;
    finish_frame(2);
    expect_launch(0, 1'b1);
    finish_frame(2);
    expect_launch(2, 1'b0);
    Req = 4'b0000;
    finish_frame(2);
    chk("t3_frame_cnt", 32'(Frame_Cnt), 3);

    // 4: watchdog abort at ND+TIMEOUT+1
    do_reset();
    Req = 4'b0011;
    expect_launch(0, 1'b0);
    repeat (1022) step();
    chk("t4_no_early_timeout", 32'(Timeout_Err), 0);
    chk("t4_grant_held", 32'(Grant), 4'b0001);
    step();
    chk("t4_timeout", 32'(Timeout_Err), 1);
    chk("t4_grant_clear", 32'(Grant), 0);
    chk("t4_frame_cnt", 32'(Frame_Cnt), 0);
    step();
    chk("t4_timeout_pulse", 32'(Timeout_Err), 0);
    expect_launch(1, 1'b0);
    Req = 4'b0000;
    finish_frame(2);

    // 5: Rx_Window cadence and Frame_Cnt wrap
    do_reset();
    Req = 4'b0001;
    for (int f = 1; f <= 256; f++) begin
      expect_launch(0, 1'b0);
      finish_frame(1);
      if (f == 13)  chk("t5_rx_13", 32'(rx_seen), 0);
      if (f == 14)  chk("t5_rx_14", 32'(rx_seen), 1);
      if (f == 28)  chk("t5_rx_28", 32'(rx_seen), 2);
      if (f == 255) chk("t5_fc_255", 32'(Frame_Cnt), 255);
    end
    Req = 4'b0000;
    chk("t5_fc_wrap", 32'(Frame_Cnt), 0);
    chk("t5_rx_256", 32'(rx_seen), 18);

    // 6: asynchronous reset during WAIT
    do_reset();
    Req = 4'b0100;
    expect_launch(2, 1'b0);
    step();
    Reset = 1'b1;
    #1;
    chk("t6_rst_grant", 32'(Grant), 0);
    chk("t6_rst_busy", 32'(Busy), 0);
    chk("t6_rst_id", 32'(Grant_Id), 0);
    chk("t6_rst_fc", 32'(Frame_Cnt), 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    Req = 4'b1000;
    expect_launch(3, 1'b0);
    Req = 4'b0000;
    exp_fc = 0; exp_rx = 0;
    finish_frame(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
